l1_wb_arbiter: RTL

Shares the single Wishbone B4 (pipelined) memory port of the L1 subsystem between the instruction-cache (li) and data-cache (ld) miss/write requesters. One transaction is outstanding at a time. Grant is round-robin, with a bus watchdog that converts a hung slave into an error response. A one-cycle conflict pulse feeds the L1 event counters.

---
 rtl/l1_wb_arbiter_if.sv | 80 ++++++++
 rtl/l1_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_wb_arbiter_if.sv
// ============================================================================
//  Module      : l1_wb_arbiter_if
//  Description : Bundle of the two L1 requester channels (li, ld), the
//                conflict pulse and the pipelined Wishbone B4 master port.
//                The master modport is the arbiter's view; the slave modport
//                is the view of the requesters plus the memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

interface l1_wb_arbiter_if;
    // Instruction-cache requester
    logic                        li_req_val;
    logic [`CORE_ADDR_WIDTH-1:0] li_req_addr;
    logic                        li_req_we;
    logic [`CORE_DATA_WIDTH-1:0] li_req_data;
    logic [`CORE_BE_WIDTH-1:0]   li_req_be;
    logic                        li_req_ack;
    logic                        li_resp_val;
    logic [`CORE_DATA_WIDTH-1:0] li_resp_data;
    logic                        li_resp_err;

    // Data-cache requester
    logic                        ld_req_val;
    logic [`CORE_ADDR_WIDTH-1:0] ld_req_addr;
    logic                        ld_req_we;
    logic [`CORE_DATA_WIDTH-1:0] ld_req_data;
    logic [`CORE_BE_WIDTH-1:0]   ld_req_be;
    logic                        ld_req_ack;
    logic                        ld_resp_val;
    logic [`CORE_DATA_WIDTH-1:0] ld_resp_data;
    logic                        ld_resp_err;

    // Event counter feed
    logic                        arb_conflict;

    // Wishbone B4 pipelined master port
    logic [`CORE_ADDR_WIDTH-1:0] wb_adr_o;
    logic [`CORE_DATA_WIDTH-1:0] wb_dat_o;
    logic [`CORE_BE_WIDTH-1:0]   wb_sel_o;
    logic                        wb_we_o;
    logic                        wb_cyc_o;
    logic                        wb_stb_o;
    logic [`CORE_DATA_WIDTH-1:0] wb_dat_i;
    logic                        wb_ack_i;
    logic                        wb_err_i;
    logic                        wb_stall_i;

    modport master (
        input  li_req_val, li_req_addr, li_req_we, li_req_data, li_req_be,
        output li_req_ack, li_resp_val, li_resp_data, li_resp_err,
        input  ld_req_val, ld_req_addr, ld_req_we, ld_req_data, ld_req_be,
        output ld_req_ack, ld_resp_val, ld_resp_data, ld_resp_err,
        output arb_conflict,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );

    modport slave (
        output li_req_val, li_req_addr, li_req_we, li_req_data, li_req_be,
        input  li_req_ack, li_resp_val, li_resp_data, li_resp_err,
        output ld_req_val, ld_req_addr, ld_req_we, ld_req_data, ld_req_be,
        input  ld_req_ack, ld_resp_val, ld_resp_data, ld_resp_err,
        input  arb_conflict,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );
endinterface

`default_nettype wire

// File: rtl/l1_wb_arbiter.sv
// ============================================================================
//  Module      : l1_wb_arbiter
//  Description : Round-robin arbiter sharing one pipelined Wishbone B4 port
//                between the L1 instruction-cache and data-cache requesters.
//                Single outstanding transaction, bus watchdog converting a
//                hung slave into an error response, conflict event pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    l1_wb_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic        c_OWNER_LI     = 1'b0;
    localparam logic        c_OWNER_LD     = 1'b1;
    localparam logic [15:0] c_TIMER_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic                          r_owner;
    logic                          r_last_grant;
    logic [15:0]                   r_timer;

    logic [`CORE_ADDR_WIDTH-1:0]   r_adr;
    logic [`CORE_DATA_WIDTH-1:0]   r_dat;
    logic [`CORE_BE_WIDTH-1:0]     r_sel;
    logic                          r_we;
    logic                          r_cyc;
    logic                          r_stb;

    logic                          r_li_resp_val;
    logic                          r_ld_resp_val;
    logic                          r_li_resp_err;
    logic                          r_ld_resp_err;
    logic [`CORE_DATA_WIDTH-1:0]   r_resp_data;

    logic                          w_idle;
    logic                          w_both;
    logic                          w_grant_li;
    logic                          w_grant_ld;
    logic                          w_accept;
    logic                          w_complete;
    logic                          w_timeout;
    logic                          w_finish;

    // Round-robin grant: a lone requester wins; on a tie the one that was
    // not granted last time wins. Nothing is granted while reset is held.
    always_comb begin
        w_idle     = rst_n && (r_state == S_IDLE);
        w_both     = bus.li_req_val && bus.ld_req_val;
        w_grant_li = w_idle && bus.li_req_val &&
                     (!bus.ld_req_val || (r_last_grant == c_OWNER_LD));
        w_grant_ld = w_idle && bus.ld_req_val &&
                     (!bus.li_req_val || (r_last_grant == c_OWNER_LI));
        w_accept   = w_grant_li || w_grant_ld;
    end

    assign bus.li_req_ack   = w_grant_li;
    assign bus.ld_req_ack   = w_grant_ld;
    assign bus.arb_conflict = w_idle && w_both;

    // Next-state logic: completion on ack/err, watchdog abort when the
    // timer reaches its last allowed count without a slave response.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!bus.wb_stall_i) begin
                    if (bus.wb_ack_i || bus.wb_err_i) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                if (!w_complete && (r_timer == c_TIMER_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.wb_ack_i || bus.wb_err_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_finish = w_complete || w_timeout;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus strobes follow the next state so cyc/stb are registered and drop
    // on the same edge that completes or aborts the transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
        end else begin
            r_cyc <= (w_state_nxt != S_IDLE);
            r_stb <= (w_state_nxt == S_REQ);
        end
    end

    // Capture the winning request; the captured values keep driving the
    // bus address/data/sel/we lines until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_owner      <= c_OWNER_LI;
            r_last_grant <= c_OWNER_LD;
        end else if (w_accept) begin
            r_adr        <= w_grant_li ? bus.li_req_addr : bus.ld_req_addr;
            r_dat        <= w_grant_li ? bus.li_req_data : bus.ld_req_data;
            r_sel        <= w_grant_li ? bus.li_req_be   : bus.ld_req_be;
            r_we         <= w_grant_li ? bus.li_req_we   : bus.ld_req_we;
            r_owner      <= w_grant_li ? c_OWNER_LI      : c_OWNER_LD;
            r_last_grant <= w_grant_li ? c_OWNER_LI      : c_OWNER_LD;
        end
    end

    // Watchdog timer: zero in the first REQ cycle, counts while the bus is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_accept) begin
            r_timer <= '0;
        end else if (r_state != S_IDLE) begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // Response pulse to the owner one cycle after completion or abort;
    // ack together with err is reported as an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_li_resp_val <= 1'b0;
            r_ld_resp_val <= 1'b0;
            r_li_resp_err <= 1'b0;
            r_ld_resp_err <= 1'b0;
            r_resp_data   <= '0;
        end else begin
            r_li_resp_val <= w_finish && (r_owner == c_OWNER_LI);
            r_ld_resp_val <= w_finish && (r_owner == c_OWNER_LD);
            r_li_resp_err <= w_finish && (r_owner == c_OWNER_LI) &&
                             (w_timeout || bus.wb_err_i);
            r_ld_resp_err <= w_finish && (r_owner == c_OWNER_LD) &&
                             (w_timeout || bus.wb_err_i);
            if (w_complete) begin
                r_resp_data <= bus.wb_dat_i;
            end else if (w_timeout) begin
                r_resp_data <= '0;
            end
        end
    end

    assign bus.wb_adr_o     = r_adr;
    assign bus.wb_dat_o     = r_dat;
    assign bus.wb_sel_o     = r_sel;
    assign bus.wb_we_o      = r_we;
    assign bus.wb_cyc_o     = r_cyc;
    assign bus.wb_stb_o     = r_stb;

    assign bus.li_resp_val  = r_li_resp_val;
    assign bus.li_resp_err  = r_li_resp_err;
    assign bus.li_resp_data = r_resp_data;
    assign bus.ld_resp_val  = r_ld_resp_val;
    assign bus.ld_resp_err  = r_ld_resp_err;
    assign bus.ld_resp_data = r_resp_data;

endmodule

`default_nettype wire
